// File: rtl/ps2_scan_rx_pkg.sv
// ps2_pkg: shared prefixes, FSM states and tagged scan word for the PS/2 receiver.
package ps2_pkg;
    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
    typedef enum logic [2:0] {IDLE, SHIFT, PARITY, STOP, DECODE} ps2_state_t;
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_word_t;
    function automatic logic odd_parity_ok(input logic [7:0] code, input logic par);
        return ^{code, par};
    endfunction
endpackage

// File: rtl/ps2_scan_rx_line_filter.sv
// ps2_line_filter: synchronises ps2c/ps2d, deglitches ps2c and flags its registered falling edge.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2c,
    input  logic ps2d,
    output logic fall,
    output logic d_sync
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [1:0]    c_sync_q, c_sync_d, d_sync_q, d_sync_d;
    logic          filt_q, filt_d, fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        c_sync_d = {c_sync_q[0], ps2c};
        d_sync_d = {d_sync_q[0], ps2d};
        filt_d   = filt_q;
        cnt_d    = '0;
        // the level flips on the FILTER_LEN-th consecutive sample that disagrees with it
        if (c_sync_q[1] != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) filt_d = c_sync_q[1];
            else cnt_d = cnt_q + 1'b1;
        end
        fall_d = filt_q & ~filt_d;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            c_sync_q <= 2'b11;
            d_sync_q <= 2'b11;
            filt_q   <= 1'b1;
            cnt_q    <= '0;
            fall_q   <= 1'b0;
        end else begin
            c_sync_q <= c_sync_d;
            d_sync_q <= d_sync_d;
            filt_q   <= filt_d;
            cnt_q    <= cnt_d;
            fall_q   <= fall_d;
        end
    end
    assign fall   = fall_q;
    assign d_sync = d_sync_q[1];
endmodule

// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: PS/2 frame receiver folding E0/F0 prefixes into a tagged 10-bit scan word.
// Define PS2_TYPEMATIC_FILTER_EN to drop auto-repeated makes of a held key.
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic       done,
    output logic [9:0] data,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic          fall, d_bit;
    ps2_state_t    state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    ps2_word_t     data_q, data_d;
    logic          done_q, done_d, err_q, err_d;
    logic          emit;
`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0]    last_make_q, last_make_d;
    logic          held_q, held_d;
`endif
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk   (clk),
        .rst   (rst),
        .ps2c  (ps2c),
        .ps2d  (ps2d),
        .fall  (fall),
        .d_sync(d_bit)
    );
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tmo_d    = '0;
        ext_d    = ext_q;
        brk_d    = brk_q;
        data_d   = data_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        emit     = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
        last_make_d = last_make_q;
        held_d      = held_q;
`endif
        case (state_q)
            IDLE: if (fall) begin
                if (!d_bit) begin
                    state_d  = SHIFT;
                    bitcnt_d = '0;
                end else err_d = 1'b1;
            end
            SHIFT: if (fall) begin
                shift_d  = {d_bit, shift_q[7:1]};
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: if (fall) begin
                par_d   = d_bit;
                state_d = STOP;
            end
            STOP: if (fall) begin
                if (d_bit && odd_parity_ok(shift_q, par_q)) state_d = DECODE;
                else begin
                    err_d   = 1'b1;
                    ext_d   = 1'b0;
                    brk_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            DECODE: begin
                state_d = IDLE;
                if (shift_q == PS2_EXT_PREFIX) ext_d = 1'b1;
                else if (shift_q == PS2_BRK_PREFIX) brk_d = 1'b1;
                else begin
                    emit  = 1'b1;
                    ext_d = 1'b0;
                    brk_d = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
                    if (!brk_q) begin
                        if (held_q && last_make_q == {ext_q, shift_q}) emit = 1'b0;
                        else begin
                            last_make_d = {ext_q, shift_q};
                            held_d      = 1'b1;
                        end
                    end else if (last_make_q == {ext_q, shift_q}) held_d = 1'b0;
`endif
                end
                if (emit) begin
                    data_d = {ext_q, brk_q, shift_q};
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // a stalled frame is abandoned silently; prefix flags survive
        if ((state_q == SHIFT || state_q == PARITY || state_q == STOP) && !fall) begin
            if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d  = IDLE;
                bitcnt_d = '0;
            end else tmo_d = tmo_q + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tmo_q    <= '0;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tmo_q    <= tmo_d;
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            data_q   <= data_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end
`ifdef PS2_TYPEMATIC_FILTER_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_make_q <= '0;
            held_q      <= 1'b0;
        end else begin
            last_make_q <= last_make_d;
            held_q      <= held_d;
        end
    end
`endif
    assign done      = done_q;
    assign data      = data_q;
    assign frame_err = err_q;
endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb_ps2_scan_rx: randomized PS/2 frames against a prefix-folding reference model with a scoreboard.
module tb_ps2_scan_rx;
    localparam int TMO = 2000;
    logic       clk = 1'b0, rst = 1'b0, ps2c = 1'b1, ps2d = 1'b1;
    logic       done, frame_err;
    logic [9:0] data;
    int tests = 0, fails = 0, cyc = 0, last_fall = 0;
    typedef struct {bit err; logic [9:0] w;} exp_t;
    exp_t q[$];
    exp_t e;
    bit m_ext = 0, m_brk = 0, m_held = 0;
    logic [8:0] m_last = '0;

    ps2_scan_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .ps2c(ps2c), .ps2d(ps2d),
        .done(done), .data(data), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void model_frame(input logic [7:0] code, input bit bad);
        bit keep;
        keep = 1;
        if (bad) begin
            q.push_back(exp_t'{1'b1, 10'h000});
            m_ext = 0;
            m_brk = 0;
        end else if (code == 8'hE0) m_ext = 1;
        else if (code == 8'hF0) m_brk = 1;
        else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (!m_brk) begin
                if (m_held && m_last == {m_ext, code}) keep = 0;
                else begin
                    m_last = {m_ext, code};
                    m_held = 1;
                end
            end else if (m_last == {m_ext, code}) m_held = 0;
`endif
            if (keep) q.push_back(exp_t'{1'b0, {m_ext, m_brk, code}});
            m_ext = 0;
            m_brk = 0;
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b, input int h);
        ps2d = b;
        tick(h);
        ps2c = 1'b0;
        last_fall = cyc;
        tick(h);
        ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad);
        int h;
        h = $urandom_range(15, 30);
        model_frame(code, bad);
        send_bit(1'b0, h);
        for (int i = 0; i < 8; i++) send_bit(code[i], h);
        send_bit((~^code) ^ bad, h);
        send_bit(1'b1, h);
        tick(h);
    endtask

    task automatic send_partial(input int n);
        send_bit(1'b0, 20);
        for (int i = 1; i < n; i++) send_bit(1'($urandom_range(0, 1)), 20);
        tick(20);
    endtask

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst && (done || frame_err)) begin
            tests++;
            if (done && frame_err) begin
                fails++;
                $display("FAIL both_high: done=%b frame_err=%b expected not both", done, frame_err);
            end else if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected: done=%b frame_err=%b data=%h expected nothing", done, frame_err, data);
            end else begin
                e = q.pop_front();
                if (e.err != frame_err || (done && data !== e.w)) begin
                    fails++;
                    $display("FAIL scoreboard: err=%b data=%h expected err=%b data=%h", frame_err, data, e.err, e.w);
                end
                tests++;
                if (cyc - last_fall != (frame_err ? 11 : 12)) begin
                    fails++;
                    $display("FAIL latency: got %0d expected %0d", cyc - last_fall, frame_err ? 11 : 12);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        chk("rst_done", {9'd0, done}, 10'd0);
        chk("rst_err", {9'd0, frame_err}, 10'd0);
        chk("rst_data", data, 10'h000);
        rst = 1'b1;
        tick(20);
        send_frame(8'h1C, 0);
        send_frame(8'hF0, 0); send_frame(8'h1C, 0);
        send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h75, 0);
        send_frame(8'hE0, 0); send_frame(8'h75, 0);
        send_frame(8'hE0, 0); send_frame(8'h1C, 1); send_frame(8'h1C, 0);
        repeat (6) begin
            ps2c = 1'b0;
            tick($urandom_range(1, 5));
            ps2c = 1'b1;
            tick(20);
        end
        send_partial(5);
        tick(TMO + 100);
        send_frame(8'h29, 0);
        send_frame(8'hE0, 0);
        send_partial(5);
        tick(TMO + 100);
        send_frame(8'h75, 0);
        send_frame(8'hE0, 0);
        send_partial(4);
        rst = 1'b0;
        tick(1);
        chk("midrst_done", {9'd0, done}, 10'd0);
        chk("midrst_err", {9'd0, frame_err}, 10'd0);
        chk("midrst_data", data, 10'h000);
        rst = 1'b1;
        m_ext = 0; m_brk = 0; m_held = 0;
        tick(20);
        send_frame(8'h1C, 0);
        send_frame(8'h1C, 0); send_frame(8'h1C, 0); send_frame(8'h1C, 0);
        send_frame(8'hF0, 0); send_frame(8'h1C, 0); send_frame(8'h1C, 0);
        repeat (40) begin
            logic [7:0] c;
            c = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 8'hE0 : 8'hF0) : 8'($urandom_range(0, 255));
            send_frame(c, $urandom_range(0, 7) == 0);
        end
        tick(50);
        chk("pending", 10'(q.size()), 10'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
